// File: rtl/i2s_tx_tdm_channel.sv
// Purpose: I2S/TDM serial transmitter, 1..MAX_SLOTS slots of up to DATA_W bits per frame.
// Latency: first slot-0 bit on the negedge after fs is seen (one bit later with ws delay).
// Backpressure: one-word shadow prefetch; fifo_ready_o only while enabled and the shadow is empty.
module i2s_tx_tdm_channel #(
  parameter int DATA_W    = 32,
  parameter int MAX_SLOTS = 8,
  parameter int WLEN_W    = $clog2(DATA_W),
  parameter int SLOT_W    = $clog2(MAX_SLOTS)
) (
  input  logic              sck_i,
  input  logic              rstn_i,
  input  logic              i2s_ws_i,
  output logic              i2s_sd_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  input  logic              fifo_valid_i,
  output logic              fifo_ready_o,
  output logic              fifo_err_o,
  output logic              frame_err_o,
  output logic [SLOT_W-1:0] status_slot_o,
  input  logic              cfg_en_i,
  input  logic [WLEN_W-1:0] cfg_wlen_i,
  input  logic [SLOT_W-1:0] cfg_slots_i,
  input  logic              cfg_lsb_first_i,
  input  logic              cfg_ws_delay_i,
  input  logic              cfg_underrun_zero_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRELOAD = 3'd1,
    WAIT_FS = 3'd2,
    DLY     = 3'd3,
    RUN     = 3'd4,
    PAD     = 3'd5
  } state_t;

  state_t              state;
  logic                r_ws;
  logic                fs;
  logic [DATA_W-1:0]   shadow;
  logic                shadow_full;
  logic [DATA_W-1:0]   word;
  logic [WLEN_W-1:0]   bit_cnt;
  logic [WLEN_W-1:0]   bit_idx;
  logic [SLOT_W-1:0]   slot_cnt;
  logic                fill;
  logic                slot_end;
  logic                frame_end;
  logic                start_fs;
  logic                load_first;
  logic                load_next;
  logic                load;
  logic                sd_next;

  assign fs           = i2s_ws_i & ~r_ws;
  assign fifo_ready_o = (state != IDLE) & ~shadow_full;
  assign fill         = fifo_valid_i & fifo_ready_o;

  // Last bit of the current slot, and last bit of the whole frame.
  assign slot_end  = (state == RUN) && (bit_cnt == cfg_wlen_i);
  assign frame_end = slot_end && (slot_cnt == cfg_slots_i);

  // Any rising ws edge outside the preload phases starts a frame; inside RUN it
  // either continues seamlessly (frame_end) or aborts the frame in progress.
  assign start_fs   = cfg_en_i & fs & ((state == WAIT_FS) | (state == PAD) | (state == RUN));
  assign load_first = (start_fs & ~cfg_ws_delay_i) | (cfg_en_i & (state == DLY));
  assign load_next  = cfg_en_i & slot_end & ~frame_end & ~fs;
  assign load       = load_first | load_next;

  assign status_slot_o = (state == RUN) ? slot_cnt : '0;

  // Select the bit for the current position; only RUN drives real data.
  always_comb begin
    bit_idx = cfg_lsb_first_i ? bit_cnt : (cfg_wlen_i - bit_cnt);
    sd_next = 1'b0;
    if (state == RUN) sd_next = word[bit_idx];
  end

  // Frame-sync edge detector: remembers ws from the previous bit clock.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) r_ws <= 1'b0;
    else         r_ws <= i2s_ws_i;
  end

  // Sequencer: FSM, shadow prefetch, slot loads, counters and error pulses.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      shadow      <= '0;
      shadow_full <= 1'b0;
      word        <= '0;
      bit_cnt     <= '0;
      slot_cnt    <= '0;
      fifo_err_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      fifo_err_o  <= 1'b0;
      frame_err_o <= 1'b0;

      // A load consumes the old shadow; a word accepted in the same cycle stays.
      if (fill) shadow <= fifo_data_i;
      if (!cfg_en_i)   shadow_full <= 1'b0;
      else if (load)   shadow_full <= fill;
      else if (fill)   shadow_full <= 1'b1;

      if (load) begin
        if (shadow_full) begin
          word <= shadow;
        end else begin
          fifo_err_o <= 1'b1;
          if (cfg_underrun_zero_i) word <= '0;
        end
        bit_cnt  <= '0;
        slot_cnt <= load_first ? '0 : slot_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (cfg_en_i) state <= PRELOAD;
        end
        PRELOAD: begin
          if (shadow_full) state <= WAIT_FS;
        end
        WAIT_FS: begin
          if (fs) state <= cfg_ws_delay_i ? DLY : RUN;
        end
        DLY: begin
          state <= RUN;
        end
        RUN: begin
          if (fs) begin
            if (!frame_end) frame_err_o <= 1'b1;
            state <= cfg_ws_delay_i ? DLY : RUN;
          end else if (frame_end) begin
            state <= PAD;
          end else if (!slot_end) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PAD: begin
          if (fs) state <= cfg_ws_delay_i ? DLY : RUN;
        end
        default: state <= IDLE;
      endcase

      // Disable wins over everything: drop back to IDLE and forget the prefetch.
      if (!cfg_en_i) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        slot_cnt    <= '0;
        fifo_err_o  <= 1'b0;
        frame_err_o <= 1'b0;
      end
    end
  end

  // Serial data changes on the falling edge so the receiver samples mid-bit.
  always_ff @(negedge sck_i or negedge rstn_i) begin
    if (!rstn_i) i2s_sd_o <= 1'b0;
    else         i2s_sd_o <= sd_next;
  end

endmodule

// File: tb/tb_i2s_tx_tdm_channel.sv
// Purpose: directed bench for i2s_tx_tdm_channel (stereo, TDM, underrun, early fs, disable, reset).
// Latency: outputs sampled 1 time unit after each sck negedge; inputs change in the same low phase.
// Backpressure: FIFO source model pops a word only after a valid&ready posedge.
module tb_i2s_tx_tdm_channel;

  logic        sck;
  logic        rstn;
  logic        ws;
  logic        sd;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_ready;
  logic        fifo_err;
  logic        frame_err;
  logic [2:0]  status_slot;
  logic        cfg_en;
  logic [4:0]  cfg_wlen;
  logic [2:0]  cfg_slots;
  logic        cfg_lsb;
  logic        cfg_dly;
  logic        cfg_uz;

  int          n_assert;
  int          n_fail;
  int          n_fifo_err;
  int          n_frame_err;

  logic [31:0] q[$];
  logic        sd_log[$];
  logic [2:0]  st_log[$];
  logic        fe_log[$];
  logic        fr_log[$];

  i2s_tx_tdm_channel #(.DATA_W(32), .MAX_SLOTS(8)) dut (
    .sck_i               (sck),
    .rstn_i              (rstn),
    .i2s_ws_i            (ws),
    .i2s_sd_o            (sd),
    .fifo_data_i         (fifo_data),
    .fifo_valid_i        (fifo_valid),
    .fifo_ready_o        (fifo_ready),
    .fifo_err_o          (fifo_err),
    .frame_err_o         (frame_err),
    .status_slot_o       (status_slot),
    .cfg_en_i            (cfg_en),
    .cfg_wlen_i          (cfg_wlen),
    .cfg_slots_i         (cfg_slots),
    .cfg_lsb_first_i     (cfg_lsb),
    .cfg_ws_delay_i      (cfg_dly),
    .cfg_underrun_zero_i (cfg_uz)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_valid = (q.size() > 0);
    fifo_data  = (q.size() > 0) ? q[0] : 32'h0;
  endtask

  task automatic push(input logic [31:0] w);
    q.push_back(w);
    drive_fifo();
  endtask

  // One bit clock: the handshake decided now happens at the coming posedge.
  task automatic tick();
    logic acc;
    acc = fifo_valid && fifo_ready;
    @(negedge sck);
    #1;
    if (acc && q.size() > 0) void'(q.pop_front());
    drive_fifo();
    sd_log.push_back(sd);
    st_log.push_back(status_slot);
    fe_log.push_back(fifo_err);
    fr_log.push_back(frame_err);
    if (fifo_err)  n_fifo_err++;
    if (frame_err) n_frame_err++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    sd_log.delete();
    st_log.delete();
    fe_log.delete();
    fr_log.delete();
    n_fifo_err  = 0;
    n_frame_err = 0;
  endtask

  task automatic set_cfg(input logic [4:0] wlen, input logic [2:0] slots,
                         input logic lsb, input logic dly, input logic uz);
    cfg_wlen  = wlen;
    cfg_slots = slots;
    cfg_lsb   = lsb;
    cfg_dly   = dly;
    cfg_uz    = uz;
  endtask

  task automatic shut_down();
    cfg_en = 1'b0;
    ws     = 1'b0;
    run(3);
  endtask

  // Concatenate n logged sd bits starting at index a, first bit most significant.
  function automatic logic [63:0] pick(input int a, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], sd_log[a+i]};
    return v;
  endfunction

  initial begin
    logic [23:0] st_pack;
    n_assert = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    ws       = 1'b0;
    cfg_en   = 1'b0;
    set_cfg(5'd15, 3'd1, 1'b0, 1'b1, 1'b1);
    drive_fifo();
    clear_log();

    // Reset state
    run(2);
    check("rst_sd",     64'(sd),          64'h0);
    check("rst_ready",  64'(fifo_ready),  64'h0);
    check("rst_ferr",   64'(fifo_err),    64'h0);
    check("rst_frerr",  64'(frame_err),   64'h0);
    check("rst_status", 64'(status_slot), 64'h0);
    rstn = 1'b1;
    run(2);

    // Stereo I2S, one-bit delay, MSB first
    set_cfg(5'd15, 3'd1, 1'b0, 1'b1, 1'b1);
    cfg_en = 1'b1;
    push(32'h0000_A5F0);
    push(32'h0000_1234);
    run(5);
    clear_log();
    ws = 1'b1;
    run(36);
    check("st_dly_bit",  64'(sd_log[0]), 64'h0);
    check("st_data",     pick(1, 32),    64'hA5F0_1234);
    check("st_pad",      pick(33, 3),    64'h0);
    check("st_ferr",     64'(n_fifo_err),  64'h0);
    check("st_frerr",    64'(n_frame_err), 64'h0);
    shut_down();

    // TDM 8 slots, LSB first, no delay; second fs lands exactly at frame end
    set_cfg(5'd7, 3'd7, 1'b1, 1'b0, 1'b1);
    cfg_en = 1'b1;
    for (int i = 1; i <= 8; i++) push(32'(i));
    for (int i = 1; i <= 8; i++) push(32'(i * 16));
    run(5);
    clear_log();
    ws = 1'b1;
    run(10);
    ws = 1'b0;
    run(54);
    ws = 1'b1;
    run(68);
    check("tdm_frame1", pick(0, 64),  64'h8040_C020_A060_E010);
    check("tdm_frame2", pick(64, 64), 64'h0804_0C02_0A06_0E01);
    check("tdm_pad",    pick(128, 4), 64'h0);
    st_pack = '0;
    for (int k = 0; k < 8; k++) st_pack = {st_pack[20:0], st_log[8*k]};
    check("tdm_status_steps", 64'(st_pack),    64'(24'o01234567));
    check("tdm_status_last",  64'(st_log[63]), 64'h7);
    check("tdm_status_f2",    64'(st_log[64]), 64'h0);
    check("tdm_status_pad",   64'(st_log[128]), 64'h0);
    check("tdm_ferr",  64'(n_fifo_err),  64'h0);
    check("tdm_frerr", 64'(n_frame_err), 64'h0);
    shut_down();

    // Underrun, send zeros
    set_cfg(5'd7, 3'd3, 1'b0, 1'b0, 1'b1);
    cfg_en = 1'b1;
    push(32'h0000_005A);
    run(4);
    clear_log();
    ws = 1'b1;
    run(36);
    check("ur0_data",   pick(0, 32), 64'h5A00_0000);
    check("ur0_pad",    pick(32, 4), 64'h0);
    check("ur0_pulses", 64'({fe_log[8], fe_log[16], fe_log[24]}), 64'h7);
    check("ur0_count",  64'(n_fifo_err),  64'h3);
    check("ur0_frerr",  64'(n_frame_err), 64'h0);
    shut_down();

    // Underrun, repeat last word
    set_cfg(5'd7, 3'd3, 1'b0, 1'b0, 1'b0);
    cfg_en = 1'b1;
    push(32'h0000_00C3);
    run(4);
    clear_log();
    ws = 1'b1;
    run(36);
    check("ur1_data",  pick(0, 32), 64'hC3C3_C3C3);
    check("ur1_count", 64'(n_fifo_err), 64'h3);
    shut_down();

    // Early frame sync after 70 bits of a 4x32-bit frame
    set_cfg(5'd31, 3'd3, 1'b0, 1'b0, 1'b1);
    cfg_en = 1'b1;
    push(32'h1111_1111);
    push(32'h2222_2222);
    push(32'h3333_3333);
    push(32'hDEAD_BEEF);
    push(32'h0123_4567);
    push(32'h89AB_CDEF);
    push(32'hCAFE_F00D);
    run(4);
    clear_log();
    ws = 1'b1;
    run(10);
    ws = 1'b0;
    run(60);
    ws = 1'b1;
    run(130);
    check("efs_w0",      pick(0, 32),   64'h1111_1111);
    check("efs_w1",      pick(32, 32),  64'h2222_2222);
    check("efs_w2_part", pick(64, 6),   64'h0C);
    check("efs_w3",      pick(70, 32),  64'hDEAD_BEEF);
    check("efs_w4",      pick(102, 32), 64'h0123_4567);
    check("efs_w5",      pick(134, 32), 64'h89AB_CDEF);
    check("efs_w6",      pick(166, 32), 64'hCAFE_F00D);
    check("efs_pad",     pick(198, 2),  64'h0);
    check("efs_slot_before", 64'(st_log[69]), 64'h2);
    check("efs_slot_after",  64'(st_log[70]), 64'h0);
    check("efs_pulse",   64'(fr_log[70]),   64'h1);
    check("efs_frcount", 64'(n_frame_err),  64'h1);
    check("efs_ferr",    64'(n_fifo_err),   64'h0);
    shut_down();

    // Disable mid-slot, then re-enable
    set_cfg(5'd15, 3'd1, 1'b0, 1'b0, 1'b1);
    cfg_en = 1'b1;
    push(32'h0000_FFFF);
    push(32'h0000_FFFF);
    run(4);
    clear_log();
    ws = 1'b1;
    run(5);
    check("dis_before", 64'(sd_log[4]), 64'h1);
    cfg_en = 1'b0;
    ws     = 1'b0;
    run(1);
    check("dis_sd_next",  64'(sd_log[5]),  64'h0);
    check("dis_ready",    64'(fifo_ready), 64'h0);
    run(3);
    check("dis_sd_quiet", pick(5, 4), 64'h0);
    push(32'h0000_8001);
    push(32'h0000_7FFE);
    run(2);
    check("dis_ready_idle", 64'(fifo_ready), 64'h0);
    cfg_en = 1'b1;
    run(1);
    check("re_ready_preload", 64'(fifo_ready), 64'h1);
    run(3);
    clear_log();
    ws = 1'b1;
    run(34);
    check("re_data",  pick(0, 32), 64'h8001_7FFE);
    check("re_pad",   pick(32, 2), 64'h0);
    check("re_ferr",  64'(n_fifo_err),  64'h0);
    check("re_frerr", 64'(n_frame_err), 64'h0);
    shut_down();

    // Asynchronous reset in the middle of slot 1
    set_cfg(5'd15, 3'd1, 1'b0, 1'b0, 1'b1);
    cfg_en = 1'b1;
    push(32'h0000_FFFF);
    push(32'h0000_FFFF);
    run(4);
    ws = 1'b1;
    run(20);
    check("mid_status", 64'(status_slot), 64'h1);
    check("mid_sd",     64'(sd),          64'h1);
    #2;
    rstn = 1'b0;
    ws   = 1'b0;
    q.delete();
    drive_fifo();
    #1;
    check("arst_sd",     64'(sd),          64'h0);
    check("arst_ready",  64'(fifo_ready),  64'h0);
    check("arst_status", 64'(status_slot), 64'h0);
    check("arst_errs",   64'({fifo_err, frame_err}), 64'h0);
    run(2);
    rstn = 1'b1;
    push(32'h0000_0F0F);
    push(32'h0000_F0F0);
    run(4);
    clear_log();
    ws = 1'b1;
    run(34);
    check("post_rst_data", pick(0, 32), 64'h0F0F_F0F0);
    check("post_rst_errs", 64'(n_fifo_err + n_frame_err), 64'h0);
    shut_down();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_tdm_channel.md
Name: i2s_tx_tdm_channel

Overview:
Parametrised I2S/TDM serial transmitter running in the sck_i domain. It pulls words from a uDMA TX FIFO and serialises 1..MAX_SLOTS slots per frame on one data line. Slot width, bit order and frame-sync delay are configurable. Underrun and early-frame-sync conditions are reported instead of silently dropped. It is the multi-slot, configurable-width successor of the stereo TX channel and sits between the TX FIFO/clock-domain crossing and the pad.

Parameters:
DATA_W, 32, width of a FIFO word and maximum slot width in bits
MAX_SLOTS, 8, maximum slots per frame (power of 2, >=2)
WLEN_W, $clog2(DATA_W), width of cfg_wlen_i
SLOT_W, $clog2(MAX_SLOTS), width of cfg_slots_i and status_slot_o

Ports:
sck_i  in  1  serial bit clock; all logic on posedge except sd output
rstn_i  in  1  reset, asynchronous, active-low
i2s_ws_i  in  1  frame sync / word select from clock generator
i2s_sd_o  out  1  serial data, updated on negedge sck_i
fifo_data_i  in  DATA_W  next word from TX FIFO
fifo_valid_i  in  1  FIFO word valid
fifo_ready_o  out  1  word accepted when valid&ready at posedge
fifo_err_o  out  1  one-cycle pulse: underrun at slot load
frame_err_o  out  1  one-cycle pulse: ws rising edge before last slot finished
status_slot_o  out  SLOT_W  slot currently being shifted
cfg_en_i  in  1  channel enable
cfg_wlen_i  in  WLEN_W  slot width minus 1 (bits)
cfg_slots_i  in  SLOT_W  slots per frame minus 1 (1 = classic stereo)
cfg_lsb_first_i  in  1  1: LSB first, 0: MSB first
cfg_ws_delay_i  in  1  1: I2S one-bit delay after frame sync, 0: left-justified/DSP
cfg_underrun_zero_i  in  1  on underrun send zeros (1) or repeat last word (0)

Behaviour:
- Reset: all outputs 0. State IDLE. Shift word, shadow word and counters cleared. Shadow empty.
- Frame sync: r_ws <= i2s_ws_i each posedge. fs = i2s_ws_i & ~r_ws (rising edge).
- Shadow buffer: 1-word prefetch. fifo_ready_o = (state != IDLE) & shadow_empty. A handshake fills the shadow. A slot load empties it. Fill and load in the same cycle are legal: the load takes the old shadow and the new word stays.
- FSM:
  - IDLE: when cfg_en_i is high, go to PRELOAD.
  - PRELOAD: once the shadow is full, go to WAIT_FS.
  - WAIT_FS: on fs, start frame; go to RUN (or DLY if cfg_ws_delay_i).
  - DLY: one cycle, then load slot 0 and go to RUN.
  - RUN: shift slots. After the last bit of slot cfg_slots_i, go to PAD.
  - PAD: output 0 until fs, then start a new frame.
- Slot load (frame start, or bit_cnt==cfg_wlen_i in RUN):
  - word <= shadow.
  - If the shadow is empty, word <= 0 or last word (per cfg_underrun_zero_i) and pulse fifo_err_o.
  - bit_cnt <= 0. slot_cnt <= 0 at frame start, otherwise slot_cnt+1.
- Output bit: MSB-first sends word[cfg_wlen_i - bit_cnt]; LSB-first sends word[bit_cnt]. Bits above cfg_wlen_i are never sent. The value is registered to i2s_sd_o on the next negedge. It is 0 in IDLE, PRELOAD, WAIT_FS, DLY and PAD.
- Latency: with fs detected at posedge k, the first slot-0 bit appears at the negedge after posedge k (delay=0) or posedge k+1 (delay=1).
- fs during RUN before the last slot completes:
  - Pulse frame_err_o.
  - Abort the current slot and restart at slot 0 with a normal slot load, including underrun handling.
- Frame ending exactly as fs arrives: start the next frame directly from RUN, no PAD cycle and no error.
- cfg_en_i low: the next posedge forces IDLE, empties the shadow (word discarded) and drops ready. i2s_sd_o is 0 from the following negedge.
- Config registers: sampled directly. Software changes them only while cfg_en_i is low.
- status_slot_o = slot_cnt; 0 outside RUN.

Test Plan:
- Stereo I2S, DATA_W=32, wlen=15, slots=1, MSB-first, delay=1, FIFO words 0xA5F0, 0x1234 -> sd_o shows 16 bits 0xA5F0 then 0x1234, starting 2 negedges after ws rises; no error pulses.
- TDM 8 slots, wlen=7, LSB-first, delay=0, words 0x01..0x08 -> eight bytes LSB-first back-to-back; status_slot_o steps 0..7; then PAD zeros until the next fs.
- Underrun: valid deasserted after 1 word, slots=3 -> fifo_err_o pulses at loads of slots 1, 2, 3. Data is zeros (underrun_zero=1) or a repeat of the previous word (underrun_zero=0).
- Early fs: slots=3, wlen=31, ws rises after 70 bits -> frame_err_o one pulse; slot 0 restarts with the next FIFO word.
- cfg_en_i dropped mid-slot, then reasserted -> sd_o 0 from the next negedge, ready low, shadow cleared. On re-enable: PRELOAD, WAIT_FS, clean frame.
- rstn_i asserted mid-frame -> all outputs 0 immediately; operation resumes from IDLE after release.
